// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered FP command issue stage that drives a single-op alu handshake
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic             cmd_round,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  output logic [2:0]       alu_op_code,
  output logic             alu_mode_fp,
  output logic             alu_round_mode,
  output logic             alu_start,
  input  logic [31:0]      alu_result,
  input  logic             alu_valid_out,
  input  logic [4:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_flags,
  output logic [TAG_W-1:0] res_tag,
  output logic [4:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic             timeout_err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int EW = 32 + 32 + 3 + 1 + 1 + TAG_W;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t            state;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [TAG_W-1:0]  tag, cur_tag;
  logic [TW-1:0]     timer;
  logic              full, empty, push, pop, expire, capture;
  logic [31:0]       cap_data;
  logic [4:0]        cap_flags;
  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = state == IDLE && !empty && (!res_valid || res_ready);
  assign expire    = state == ISSUE && !alu_valid_out && timer == TW'(TIMEOUT_CYC - 1);
  assign capture   = (state == ISSUE && alu_valid_out) || expire;
  assign cap_data  = expire ? 32'd0 : alu_result;
  assign cap_flags = expire ? 5'b10000 : alu_flags;
  assign busy      = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round, tag};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      tag            <= '0;
      cur_tag        <= '0;
      timer          <= '0;
      alu_op_a       <= '0;
      alu_op_b       <= '0;
      alu_op_code    <= '0;
      alu_mode_fp    <= 1'b0;
      alu_round_mode <= 1'b0;
      alu_start      <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_flags      <= '0;
      res_tag        <= '0;
      sticky_flags   <= '0;
      timeout_err    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      count        <= count + (AW+1)'(push) - (AW+1)'(pop);
      tag          <= tag + TAG_W'(push);
      timeout_err  <= expire;
      sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | (capture ? cap_flags : 5'b0);
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= cap_data;
        res_flags <= cap_flags;
        res_tag   <= cur_tag;
      end else if (res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          {alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode, cur_tag} <= mem[rd_ptr];
          alu_start <= 1'b1;
          timer     <= '0;
          state     <= ISSUE;
        end
        ISSUE: if (capture) begin
          alu_start <= 1'b0;
          state     <= DRAIN;
        end else timer <= timer + 1'b1;
        DRAIN: if (!alu_valid_out) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
